// File: rtl/draw_sprite_pkg.sv
// Shared types and colour constants for the sprite overlay stage.
package draw_sprite_pkg;

    localparam logic [11:0] BLACK = 12'h000;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing and colour bundle passed between draw stages.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_sprite_delay.sv
// Fixed-length shift register used to align timing with the ROM read.
module draw_sprite_delay #(
    parameter int WIDTH   = 39,
    parameter int CLK_DEL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] stage [CLK_DEL];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CLK_DEL; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < CLK_DEL; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[CLK_DEL-1];
endmodule

// File: rtl/draw_sprite.sv
// Sprite overlay stage: fetches a rectangular sprite from an external ROM and
// keys it over the incoming VGA stream. Placement inputs are shadowed at vblank.
module draw_sprite
    import draw_sprite_pkg::*;
#(
    parameter int          SPRITE_W  = 300,
    parameter int          SPRITE_H  = 300,
    parameter int          FRAMES    = 1,
    parameter int          ROM_LAT   = 1,
    parameter int          ADDR_W    = 20,
    parameter logic [11:0] KEY_COLOR = BLACK,
    localparam int         FSEL_W    = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       x_pos,
    input  logic [10:0]       y_pos,
    input  logic [FSEL_W-1:0] frame_sel,
    input  logic              mirror,
    input  logic              enable,
    input  logic [11:0]       rgb_pixel,
    output logic [ADDR_W-1:0] pixel_addr,
    vga_if.in                 in,
    vga_if.out                out
);
    localparam int         LAT        = ROM_LAT + 2;
    localparam int         FRAME_SIZE = SPRITE_W * SPRITE_H;
    localparam logic [9:0] LAST_COL   = 10'(SPRITE_W - 1);

    logic [10:0]       x_l, y_l;
    logic [FSEL_W-1:0] frame_l, frame_clamped;
    logic              mirror_l, en_l, vblnk_prev, latch_d;
    logic [ADDR_W-1:0] frame_base_l, row_base;
    logic [9:0]        col, col_eff;
    logic [11:0]       h12, v12, x_end, y_end;
    logic              vblnk_rise, in_rows, hit, hit_d;
    vga_t              vga_in, vga_d;

    assign vblnk_rise = in.vblnk && !vblnk_prev;

    always_comb begin
        frame_clamped = frame_sel;
        if (int'(frame_sel) > FRAMES - 1) frame_clamped = FSEL_W'(FRAMES - 1);
    end

    // vblnk_prev resets high so a vblank already in progress at reset release is not taken as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_l          <= '0;
            y_l          <= '0;
            frame_l      <= '0;
            mirror_l     <= 1'b0;
            en_l         <= 1'b0;
            vblnk_prev   <= 1'b1;
            latch_d      <= 1'b0;
            frame_base_l <= '0;
        end else begin
            vblnk_prev <= in.vblnk;
            latch_d    <= vblnk_rise;
            if (vblnk_rise) begin
                x_l      <= x_pos;
                y_l      <= y_pos;
                frame_l  <= frame_clamped;
                mirror_l <= mirror;
                en_l     <= enable;
            end
            if (latch_d) frame_base_l <= ADDR_W'(FRAME_SIZE * int'(frame_l));
        end
    end

    always_comb begin
        h12     = {1'b0, in.hcount};
        v12     = {1'b0, in.vcount};
        x_end   = {1'b0, x_l} + 12'(SPRITE_W);
        y_end   = {1'b0, y_l} + 12'(SPRITE_H);
        in_rows = (v12 >= {1'b0, y_l}) && (v12 < y_end);
        hit     = en_l && in_rows && (h12 >= {1'b0, x_l}) && (h12 < x_end);
        col_eff = mirror_l ? (LAST_COL - col) : col;
    end

    // Row base reloads on every line outside the sprite rows, including vblank,
    // so a sprite starting at line 0 still begins at the frame base.
    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row_base   <= '0;
            pixel_addr <= '0;
        end else begin
            col <= hit ? col + 10'd1 : '0;
            if (!in_rows)
                row_base <= frame_base_l;
            else if (hit && col == LAST_COL)
                row_base <= row_base + ADDR_W'(SPRITE_W);
            pixel_addr <= hit ? row_base + ADDR_W'(col_eff) : '0;
        end
    end

    assign vga_in = {in.hcount, in.vcount, in.hsync, in.vsync, in.hblnk, in.vblnk, in.rgb};

    draw_sprite_delay #(
        .WIDTH   ($bits(vga_t) + 1),
        .CLK_DEL (LAT - 1)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  ({vga_in, hit}),
        .dout ({vga_d, hit_d})
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out.hcount <= '0;
            out.vcount <= '0;
            out.hsync  <= 1'b0;
            out.vsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            out.hcount <= vga_d.hcount;
            out.vcount <= vga_d.vcount;
            out.hsync  <= vga_d.hsync;
            out.vsync  <= vga_d.vsync;
            out.hblnk  <= vga_d.hblnk;
            out.vblnk  <= vga_d.vblnk;
            out.rgb    <= (hit_d && rgb_pixel != KEY_COLOR) ? rgb_pixel : vga_d.rgb;
        end
    end
endmodule

// File: tb/tb_draw_sprite.sv
// Bench for draw_sprite: compressed VGA raster, behavioural sprite model and ROM.
module tb_draw_sprite;
    localparam int W = 4, H = 3, FR = 3, ROM_LAT = 1, AW = 6, LAT = ROM_LAT + 2;
    localparam int H_LEN = 36, V_LEN = 12, VB_START = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic [10:0]   x_pos, y_pos;
    logic [1:0]    frame_sel;
    logic          mirror, enable;
    logic [11:0]   rgb_pixel;
    logic [AW-1:0] pixel_addr;
    logic [11:0]   rom [64];

    vga_if vin ();
    vga_if vout ();

    draw_sprite #(
        .SPRITE_W (W), .SPRITE_H (H), .FRAMES (FR), .ROM_LAT (ROM_LAT),
        .ADDR_W (AW), .KEY_COLOR (12'h000)
    ) dut (
        .clk (clk), .rst (rst), .x_pos (x_pos), .y_pos (y_pos),
        .frame_sel (frame_sel), .mirror (mirror), .enable (enable),
        .rgb_pixel (rgb_pixel), .pixel_addr (pixel_addr),
        .in (vin), .out (vout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rgb_pixel <= rom[pixel_addr];

    int n_assert = 0, n_fail = 0;
    int m_x = 0, m_y = 0, m_f = 0;
    bit m_mir = 0, m_en = 0, m_prev_vb = 0;
    logic [37:0] exp_q [$];
    bit          skip_q [$];

    task automatic check(input string tag, input logic [37:0] obs, input logic [37:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One pixel: drive input, predict from sprite geometry, check after the edge.
    task automatic step(input int h, input int v);
        logic        hs, vs, hb, vb, hit;
        logic [11:0] bg, rgb;
        logic [37:0] e;
        bit          s;
        int          col, row, addr;
        hb = (h >= 800);
        hs = (h >= 800 && h < 805);
        vb = (v >= VB_START);
        vs = (v == 10);
        bg = 12'($urandom);
        vin.hcount = 11'(h); vin.vcount = 11'(v);
        vin.hsync = hs; vin.vsync = vs; vin.hblnk = hb; vin.vblnk = vb; vin.rgb = bg;

        hit  = m_en && h >= m_x && h < m_x + W && v >= m_y && v < m_y + H;
        addr = 0;
        if (hit) begin
            col  = h - m_x;
            row  = v - m_y;
            addr = m_f * W * H + row * W + (m_mir ? W - 1 - col : col);
        end
        rgb = (hit && rom[addr] != 12'h000) ? rom[addr] : bg;
        exp_q.push_back({11'(h), 11'(v), hs, vs, hb, vb, rgb});
        skip_q.push_back(rst);

        if (rst) begin
            m_en = 0; m_x = 0; m_y = 0; m_f = 0; m_mir = 0;
        end else if (vb && !m_prev_vb) begin
            m_x   = int'(x_pos);
            m_y   = int'(y_pos);
            m_f   = (int'(frame_sel) >= FR) ? FR - 1 : int'(frame_sel);
            m_mir = mirror;
            m_en  = enable;
        end
        m_prev_vb = vb;

        @(posedge clk);
        #1;
        if (rst) begin
            check("rst_out", {vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                              vout.hblnk, vout.vblnk, vout.rgb}, 38'd0);
            check("rst_addr", 38'(pixel_addr), 38'd0);
        end else begin
            check("addr", 38'(pixel_addr), 38'(addr));
        end
        if (exp_q.size() >= LAT) begin
            e = exp_q.pop_front();
            s = skip_q.pop_front();
            if (!rst && !s)
                check("out", {vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                              vout.hblnk, vout.vblnk, vout.rgb}, e);
        end
    endtask

    task automatic run_frame(input int scramble_line, input int rst_line);
        for (int v = 0; v < V_LEN; v++) begin
            for (int i = 0; i < H_LEN; i++) begin
                if (v == scramble_line && i == 0) begin
                    x_pos     = 11'($urandom_range(0, 12));
                    y_pos     = 11'($urandom_range(0, 5));
                    frame_sel = 2'($urandom);
                    mirror    = 1'($urandom);
                    enable    = 1'($urandom);
                end
                rst = (v == rst_line && (i == 11 || i == 12));
                step((i < 16) ? i : 774 + i, v);
            end
        end
        rst = 1'b0;
    endtask

    task automatic rom_linear();
        for (int i = 0; i < 64; i++) rom[i] = 12'(i + 1);
    endtask

    initial begin
        rst = 1'b1;
        x_pos = '0; y_pos = '0; frame_sel = '0; mirror = 1'b0; enable = 1'b0;
        rom_linear();
        for (int i = 0; i < 3; i++) step(i, 0);
        rst = 1'b0;

        x_pos = 11'd10; y_pos = 11'd5; enable = 1'b1;
        run_frame(-1, -1);
        mirror = 1'b1;
        run_frame(-1, -1);
        mirror = 1'b0; frame_sel = 2'd1;
        run_frame(-1, -1);
        run_frame(6, -1);

        x_pos = 11'd10; y_pos = 11'd5; enable = 1'b1; mirror = 1'b0; frame_sel = 2'd0;
        rom[5] = 12'h000;
        run_frame(-1, -1);
        enable = 1'b0;
        run_frame(-1, -1);
        rom_linear();
        enable = 1'b1; x_pos = 11'd798; y_pos = 11'd2;
        run_frame(-1, -1);
        x_pos = 11'd3; y_pos = 11'd4; frame_sel = 2'd3; mirror = 1'b1;
        run_frame(-1, -1);
        run_frame(-1, 5);
        run_frame(-1, -1);

        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 64; i++)
                rom[i] = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
            x_pos     = 11'($urandom_range(0, 12));
            y_pos     = 11'($urandom_range(0, 5));
            frame_sel = 2'($urandom);
            mirror    = 1'($urandom);
            enable    = ($urandom_range(0, 4) != 0);
            run_frame(($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 11)), -1);
        end
        run_frame(-1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
